// File: rtl/olive_std_core_systimer_ctrl.sv
// olive_std_core_systimer_ctrl
//
// Avalon-MM write-only master that owns a 16-bit-register interval timer.
// It programs the timer period, starts the timer in continuous mode with its
// interrupt enabled, and acknowledges every timeout by clearing the status
// register. Each acknowledged timeout advances a 32-bit system tick count.
// A bank of one-shot alarms compares against the tick count. host_irq is
// asserted while any alarm fire flag is set.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   tm_*                timer slave write port (address, chipselect,
//                       write_n, writedata) and the timer's level irq
//   cfg_enable          1 = run timer, 0 = stop timer
//   tick_load/_value    one-cycle preload of tick_count
//   alarm_set/_index/_delta
//                       arm one alarm slot at tick_count + delta
//   alarm_ack           per-slot clear of the sticky fire flags
//   alarm_fire          sticky per-slot fire flags
//   tick_count          system tick count
//   running, busy       FSM status
//   host_irq            OR of alarm_fire
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | timer stopped, no bus activity
// WR_PL   | writing period low half   (addr 2)
// WR_PH   | writing period high half  (addr 3)
// WR_CTRL | writing START|CONT|ITO    (addr 1, 0x0007)
// RUN     | timer running, waiting for a timeout
// CLR     | clearing the timeout      (addr 0, 0x0000), tick += 1
// STOP    | writing STOP              (addr 1, 0x0008)

module olive_std_core_systimer_ctrl #(
    parameter logic [31:0] PERIOD     = 32'd24999,
    parameter int          NUM_ALARMS = 4,
    parameter int          IDX_W      = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic [2:0]            tm_address,
    output logic                  tm_chipselect,
    output logic                  tm_write_n,
    output logic [15:0]           tm_writedata,
    input  logic                  tm_irq,
    input  logic                  cfg_enable,
    input  logic                  tick_load,
    input  logic [31:0]           tick_load_value,
    input  logic                  alarm_set,
    input  logic [IDX_W-1:0]      alarm_index,
    input  logic [31:0]           alarm_delta,
    input  logic [NUM_ALARMS-1:0] alarm_ack,
    output logic [NUM_ALARMS-1:0] alarm_fire,
    output logic [31:0]           tick_count,
    output logic                  running,
    output logic                  busy,
    output logic                  host_irq
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_PL   = 3'd1,
        S_WR_PH   = 3'd2,
        S_WR_CTRL = 3'd3,
        S_RUN     = 3'd4,
        S_CLR     = 3'd5,
        S_STOP    = 3'd6
    } state_t;

    localparam logic [15:0] CTRL_START = 16'h0007;
    localparam logic [15:0] CTRL_STOP  = 16'h0008;

    state_t      state;
    state_t      state_nxt;

    logic        bus_wr_nxt;
    logic [2:0]  bus_addr_nxt;
    logic [15:0] bus_data_nxt;

    // ---------------------------------------------------------------------
    // Sequencer FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, plus the bus word for the state being entered. The bus
    // registers load that word, so each write appears on the bus during
    // exactly the cycle the FSM sits in the corresponding write state.
    always_comb begin
        state_nxt    = state;
        bus_wr_nxt   = 1'b0;
        bus_addr_nxt = 3'd0;
        bus_data_nxt = 16'h0000;

        case (state)
            S_IDLE:    if (cfg_enable) state_nxt = S_WR_PL;
            S_WR_PL:   state_nxt = S_WR_PH;
            S_WR_PH:   state_nxt = S_WR_CTRL;
            S_WR_CTRL: state_nxt = S_RUN;
            S_RUN: begin
                // Stopping wins over a pending timeout.
                if (!cfg_enable) begin
                    state_nxt = S_STOP;
                end else if (tm_irq) begin
                    state_nxt = S_CLR;
                end
            end
            // The timer drops irq on the edge that ends CLR, so RUN
            // does not see the same timeout twice.
            S_CLR:     state_nxt = S_RUN;
            S_STOP:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase

        case (state_nxt)
            S_WR_PL: begin
                bus_wr_nxt   = 1'b1;
                bus_addr_nxt = 3'd2;
                bus_data_nxt = PERIOD[15:0];
            end
            S_WR_PH: begin
                bus_wr_nxt   = 1'b1;
                bus_addr_nxt = 3'd3;
                bus_data_nxt = PERIOD[31:16];
            end
            S_WR_CTRL: begin
                bus_wr_nxt   = 1'b1;
                bus_addr_nxt = 3'd1;
                bus_data_nxt = CTRL_START;
            end
            S_CLR: begin
                bus_wr_nxt   = 1'b1;
                bus_addr_nxt = 3'd0;
                bus_data_nxt = 16'h0000;
            end
            S_STOP: begin
                bus_wr_nxt   = 1'b1;
                bus_addr_nxt = 3'd1;
                bus_data_nxt = CTRL_STOP;
            end
            default: begin
                bus_wr_nxt   = 1'b0;
                bus_addr_nxt = 3'd0;
                bus_data_nxt = 16'h0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tm_chipselect <= 1'b0;
            tm_write_n    <= 1'b1;
            tm_address    <= 3'd0;
            tm_writedata  <= 16'h0000;
        end else begin
            tm_chipselect <= bus_wr_nxt;
            tm_write_n    <= ~bus_wr_nxt;
            tm_address    <= bus_addr_nxt;
            tm_writedata  <= bus_data_nxt;
        end
    end

    assign running = (state == S_RUN) || (state == S_CLR);
    assign busy    = (state == S_WR_PL) || (state == S_WR_PH) ||
                     (state == S_WR_CTRL) || (state == S_STOP);

    // ---------------------------------------------------------------------
    // System tick count
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_count <= 32'd0;
        end else if (tick_load) begin
            tick_count <= tick_load_value;
        end else if (state == S_CLR) begin
            tick_count <= tick_count + 32'd1;
        end
    end

    // ---------------------------------------------------------------------
    // One-shot alarms
    // ---------------------------------------------------------------------
    logic [31:0]           deadline [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] armed;
    logic [NUM_ALARMS-1:0] hit;
    logic [NUM_ALARMS-1:0] set_sel;

    always_comb begin
        hit     = '0;
        set_sel = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            hit[i]     = armed[i] && (deadline[i] == tick_count);
            set_sel[i] = alarm_set && (alarm_index == IDX_W'(i));
        end
    end

    // A set on a slot replaces its old deadline outright, so a hit on the
    // old deadline in the same cycle is dropped. A fresh fire beats an ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed      <= '0;
            alarm_fire <= '0;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                deadline[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (set_sel[i]) begin
                    deadline[i] <= tick_count + alarm_delta;
                    armed[i]    <= 1'b1;
                end else if (hit[i]) begin
                    armed[i]    <= 1'b0;
                end

                if (hit[i] && !set_sel[i]) begin
                    alarm_fire[i] <= 1'b1;
                end else if (alarm_ack[i]) begin
                    alarm_fire[i] <= 1'b0;
                end
            end
        end
    end

    assign host_irq = |alarm_fire;

endmodule

// File: tb/tb_olive_std_core_systimer_ctrl.sv
// Bench for olive_std_core_systimer_ctrl.
// A behavioural timer slave decodes the DUT's bus writes and raises tm_irq.
// Its timeout gap is shortened to IRQ_GAP clocks so the run stays short; the
// controller never counts the period itself, so only the gap between
// timeouts changes. Expected bus writes are queued when stimulus (or a model
// timeout) is produced and popped by a monitor when the DUT writes.

module tb_olive_std_core_systimer_ctrl;

    localparam int IRQ_GAP = 50;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  tm_address;
    logic        tm_chipselect;
    logic        tm_write_n;
    logic [15:0] tm_writedata;
    logic        tm_irq;
    logic        cfg_enable = 1'b0;
    logic        tick_load = 1'b0;
    logic [31:0] tick_load_value = 32'd0;
    logic        alarm_set = 1'b0;
    logic [1:0]  alarm_index = 2'd0;
    logic [31:0] alarm_delta = 32'd0;
    logic [3:0]  alarm_ack = 4'd0;
    logic [3:0]  alarm_fire;
    logic [31:0] tick_count;
    logic        running;
    logic        busy;
    logic        host_irq;

    olive_std_core_systimer_ctrl dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .tm_address      (tm_address),
        .tm_chipselect   (tm_chipselect),
        .tm_write_n      (tm_write_n),
        .tm_writedata    (tm_writedata),
        .tm_irq          (tm_irq),
        .cfg_enable      (cfg_enable),
        .tick_load       (tick_load),
        .tick_load_value (tick_load_value),
        .alarm_set       (alarm_set),
        .alarm_index     (alarm_index),
        .alarm_delta     (alarm_delta),
        .alarm_ack       (alarm_ack),
        .alarm_fire      (alarm_fire),
        .tick_count      (tick_count),
        .running         (running),
        .busy            (busy),
        .host_irq        (host_irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected writes as {address, writedata}.
    logic [18:0] exp_q [$];
    logic        push_en = 1'b1;
    int          n_timeouts = 0;

    // Timer slave model.
    logic        tm_run;
    int          tm_cnt;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tm_irq <= 1'b0;
            tm_run <= 1'b0;
            tm_cnt <= 0;
        end else begin
            if (tm_chipselect && !tm_write_n) begin
                if (tm_address == 3'd1 && tm_writedata[2]) begin
                    tm_run <= 1'b1;
                    tm_cnt <= 0;
                end
                if (tm_address == 3'd1 && tm_writedata[3]) tm_run <= 1'b0;
                if (tm_address == 3'd0) tm_irq <= 1'b0;
            end
            if (tm_run) begin
                if (tm_cnt == IRQ_GAP - 1) begin
                    tm_cnt     <= 0;
                    tm_irq     <= 1'b1;
                    n_timeouts <= n_timeouts + 1;
                    if (push_en) exp_q.push_back({3'd0, 16'h0000});
                end else begin
                    tm_cnt <= tm_cnt + 1;
                end
            end
        end
    end

    // Bus monitor: every write must match the head of the queue.
    always @(negedge clk) begin
        if (reset_n && tm_chipselect) begin
            check_eq("wr_strobe_n", tm_write_n, 1'b0);
            if (exp_q.size() == 0) begin
                check_eq("wr_extra", exp_q.size(), 1);
                $display("  unexpected write addr %0d data %0h", tm_address, tm_writedata);
            end else begin
                check_eq("wr_word", {tm_address, tm_writedata}, exp_q.pop_front());
            end
        end
    end

    task automatic wait_tick(input logic [31:0] target, input int budget);
        int n;
        n = 0;
        while (tick_count !== target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (tick_count !== target) check_eq("wait_tick_timeout", tick_count, target);
    endtask

    task automatic set_alarm(input logic [1:0] idx, input logic [31:0] delta);
        alarm_set   = 1'b1;
        alarm_index = idx;
        alarm_delta = delta;
    endtask

    logic [31:0] tick_hold;
    int          n;

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        check_eq("rst_cs",      tm_chipselect, 1'b0);
        check_eq("rst_wr_n",    tm_write_n,    1'b1);
        check_eq("rst_addr",    tm_address,    3'd0);
        check_eq("rst_data",    tm_writedata,  16'h0000);
        check_eq("rst_tick",    tick_count,    32'd0);
        check_eq("rst_fire",    alarm_fire,    4'd0);
        check_eq("rst_status",  {running, busy, host_irq}, 3'b000);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Init sequence.
        exp_q.push_back({3'd2, 16'h61A7});
        exp_q.push_back({3'd3, 16'h0000});
        exp_q.push_back({3'd1, 16'h0007});
        cfg_enable = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check_eq("init_busy", busy, (k <= 3) ? 1'b1 : 1'b0);
            check_eq("init_running", running, (k >= 4) ? 1'b1 : 1'b0);
        end

        // Five timeouts, one clear each, no double counting.
        wait_tick(32'd5, 8 * IRQ_GAP);
        check_eq("tick5", tick_count, 32'd5);
        check_eq("tick_vs_timeouts", tick_count, n_timeouts);
        check_eq("q_after5", exp_q.size(), 0);

        // Alarm slot 2 at tick 10, delta 3.
        wait_tick(32'd10, 8 * IRQ_GAP);
        set_alarm(2'd2, 32'd3);
        @(negedge clk);
        alarm_set = 1'b0;
        wait_tick(32'd13, 5 * IRQ_GAP);
        check_eq("a2_not_yet", alarm_fire, 4'b0000);
        @(negedge clk);
        check_eq("a2_fire", alarm_fire, 4'b0100);
        check_eq("a2_irq", host_irq, 1'b1);
        alarm_ack = 4'b0100;
        @(negedge clk);
        alarm_ack = 4'b0000;
        check_eq("a2_ack", alarm_fire, 4'b0000);
        check_eq("a2_irq_clr", host_irq, 1'b0);

        // Wrap: load 0xFFFFFFFE, alarm slot 0 delta 3 fires at 0x00000001.
        tick_load       = 1'b1;
        tick_load_value = 32'hFFFF_FFFE;
        @(negedge clk);
        tick_load = 1'b0;
        check_eq("tick_load", tick_count, 32'hFFFF_FFFE);
        set_alarm(2'd0, 32'd3);
        @(negedge clk);
        alarm_set = 1'b0;
        wait_tick(32'd0, 5 * IRQ_GAP);
        check_eq("wrap_zero", tick_count, 32'd0);
        wait_tick(32'd1, 5 * IRQ_GAP);
        check_eq("a0_not_yet", alarm_fire, 4'b0000);
        @(negedge clk);
        check_eq("a0_fire", alarm_fire, 4'b0001);
        alarm_ack = 4'b0001;
        @(negedge clk);
        alarm_ack = 4'b0000;
        check_eq("a0_ack", alarm_fire, 4'b0000);

        // Delta 0, fire-vs-ack, re-arm-vs-fire; start just after a tick.
        wait_tick(tick_count + 32'd1, 3 * IRQ_GAP);
        set_alarm(2'd1, 32'd0);
        @(negedge clk);
        alarm_set = 1'b0;
        check_eq("d0_not_yet", alarm_fire, 4'b0000);
        @(negedge clk);
        check_eq("d0_fire", alarm_fire, 4'b0010);
        set_alarm(2'd3, 32'd0);
        @(negedge clk);
        alarm_set = 1'b0;
        alarm_ack = 4'b1010;
        @(negedge clk);
        alarm_ack = 4'b0000;
        check_eq("fire_beats_ack", alarm_fire, 4'b1000);
        set_alarm(2'd2, 32'd0);
        @(negedge clk);
        set_alarm(2'd2, 32'd1000);
        @(negedge clk);
        alarm_set = 1'b0;
        check_eq("rearm_no_fire", alarm_fire, 4'b1000);
        @(negedge clk);
        check_eq("rearm_no_fire2", alarm_fire, 4'b1000);
        check_eq("rearm_irq", host_irq, 1'b1);

        // Stop coincident with a timeout: only the STOP write.
        wait_tick(tick_count + 32'd1, 3 * IRQ_GAP);
        push_en = 1'b0;
        n = 0;
        while (tm_irq !== 1'b1 && n < 3 * IRQ_GAP) begin
            @(negedge clk);
            n++;
        end
        check_eq("stop_irq_seen", tm_irq, 1'b1);
        check_eq("stop_in_run", running, 1'b1);
        tick_hold = tick_count;
        exp_q.push_back({3'd1, 16'h0008});
        cfg_enable = 1'b0;
        @(negedge clk);
        check_eq("stop_busy", busy, 1'b1);
        @(negedge clk);
        check_eq("stop_idle", {running, busy}, 2'b00);
        repeat (IRQ_GAP + 10) @(negedge clk);
        check_eq("stop_tick_hold", tick_count, tick_hold);
        check_eq("stop_q_empty", exp_q.size(), 0);

        // Reset in the middle of WR_PH.
        exp_q.push_back({3'd2, 16'h61A7});
        exp_q.push_back({3'd3, 16'h0000});
        cfg_enable = 1'b1;
        n = 0;
        while (!(tm_chipselect === 1'b1 && tm_address === 3'd3) && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_eq("in_wr_ph", tm_address, 3'd3);
        #1 reset_n = 1'b0;
        cfg_enable = 1'b0;
        #1;
        check_eq("mid_rst_cs",     tm_chipselect, 1'b0);
        check_eq("mid_rst_wr_n",   tm_write_n,    1'b1);
        check_eq("mid_rst_addr",   tm_address,    3'd0);
        check_eq("mid_rst_data",   tm_writedata,  16'h0000);
        check_eq("mid_rst_tick",   tick_count,    32'd0);
        check_eq("mid_rst_fire",   alarm_fire,    4'd0);
        check_eq("mid_rst_status", {running, busy, host_irq}, 3'b000);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("post_rst_idle", {running, busy}, 2'b00);
        check_eq("q_final", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/olive_std_core_systimer_ctrl.md
Name: olive_std_core_systimer_ctrl

Overview:
- Avalon-MM master sequencer that owns the 16-bit-register interval timer slave (addresses 0 status, 1 control, 2/3 period lo/hi, 4/5 snapshot).
- Programs the timer period, starts it in continuous mode with interrupt enabled, and services each timeout by clearing the status register.
- Maintains a 32-bit system tick count and NUM_ALARMS one-shot software alarms, and raises host_irq when any alarm fires.

Parameters:
- PERIOD, 32'd24999, timer reload value written to the period registers (counter period = PERIOD+1 clocks).
- NUM_ALARMS, 4, number of alarm slots (1..16).
- IDX_W, 2, alarm index width, clog2(NUM_ALARMS) with minimum 1.

Ports:
- clk  input  1  clock
- reset_n  input  1  reset: reset_n, asynchronous, active-low
- tm_address  output  3  timer slave address
- tm_chipselect  output  1  timer chipselect
- tm_write_n  output  1  timer write strobe, active-low
- tm_writedata  output  16  timer write data
- tm_irq  input  1  timer interrupt, level
- cfg_enable  input  1  1 = run timer, 0 = stop timer
- tick_load  input  1  load tick_count from tick_load_value (one-cycle pulse)
- tick_load_value  input  32  tick preload value
- alarm_set  input  1  arm slot alarm_index (one-cycle pulse)
- alarm_index  input  IDX_W  slot to arm
- alarm_delta  input  32  ticks from now until the alarm fires
- alarm_ack  input  NUM_ALARMS  per-slot fire-flag clear
- alarm_fire  output  NUM_ALARMS  sticky per-slot fire flags
- tick_count  output  32  system tick count
- running  output  1  FSM in RUN or CLR
- busy  output  1  FSM in WR_PL, WR_PH, WR_CTRL or STOP
- host_irq  output  1  OR of alarm_fire

Behaviour:
- Reset values:
  - FSM = IDLE.
  - tm_chipselect = 0, tm_write_n = 1, tm_address = 0, tm_writedata = 0.
  - tick_count = 0, alarm_fire = 0, all slots disarmed.
  - running = 0, busy = 0, host_irq = 0.
- Master bus rules:
  - Every access is a single write. chipselect = 1 and write_n = 0 for exactly one cycle. There are no reads and no waitrequest.
  - Outputs are registered; the bus carries the write during the cycle the FSM occupies the write state.
  - Outside write states, chipselect = 0 and write_n = 1.
- FSM states and transitions:
  - IDLE: no bus activity. cfg_enable = 1 -> WR_PL.
  - WR_PL: write addr 2, data PERIOD[15:0] -> WR_PH.
  - WR_PH: write addr 3, data PERIOD[31:16] -> WR_CTRL.
  - WR_CTRL: write addr 1, data 0x0007 (START, CONT, ITO) -> RUN.
  - RUN:
    - cfg_enable = 0 -> STOP (takes priority over tm_irq).
    - Else tm_irq = 1 -> CLR.
  - CLR: write addr 0, data 0x0000; tick_count += 1 in the same cycle -> RUN. The timer drops irq at this edge, so RUN does not retrigger.
  - STOP: write addr 1, data 0x0008 (STOP) -> IDLE.
- The init sequence (WR_PL, WR_PH, WR_CTRL) runs to completion even if cfg_enable falls mid-sequence; RUN then goes to STOP.
- Tick count:
  - Wraps modulo 2^32.
  - tick_load overrides the CLR increment in the same cycle.
  - tick_load is accepted in any state.
- Alarms:
  - Each slot holds armed and deadline[31:0].
  - alarm_set: deadline = tick_count + alarm_delta (mod 2^32, using the current registered tick_count), armed = 1.
  - Fire condition: armed && deadline == tick_count, evaluated every cycle against the registered tick_count. On fire, armed clears and alarm_fire[i] sets on the next edge.
  - alarm_delta = 0 fires on the cycle after the set.
  - alarm_set to an already-armed slot re-arms it. Set wins over a coincident fire of the old deadline: no flag for the old deadline.
  - alarm_ack[i] clears alarm_fire[i]. A new fire in the same cycle wins, so the flag stays 1.
  - tick_load does not alter deadlines. An alarm whose deadline equals the loaded value fires one cycle later.
  - Alarms evaluate regardless of FSM state; tick_count simply stops advancing outside RUN/CLR.
- host_irq = |alarm_fire, combinational from registers.
- Reset asserted mid-operation returns everything to reset values immediately, with no STOP write. The timer slave is reset by the same reset_n.

Test Plan:
- Reset, then cfg_enable = 1 -> writes (2, 0x61A7), (3, 0x0000), (1, 0x0007) on three consecutive cycles; busy = 1 for exactly those cycles; running = 1 afterwards.
- Timer model asserts tm_irq every 25000 clocks -> each assertion yields exactly one write (0, 0x0000); tick_count reads 5 after 5 timeouts; no double counting.
- At tick_count = 10, alarm_set index 2, delta 3 -> alarm_fire = 4'b0100 and host_irq = 1 one cycle after tick_count reaches 13; alarm_ack = 4'b0100 -> flags 0, host_irq = 0.
- tick_load 0xFFFFFFFE, then alarm_set index 0, delta 3 -> fires when tick_count wraps to 0x00000001.
- alarm_set with delta 0 -> fire flag one cycle later. Fire and ack on the same slot in the same cycle -> flag remains 1. Re-arm on the firing cycle -> no fire.
- cfg_enable = 0 in RUN with tm_irq = 1 the same cycle -> single write (1, 0x0008), no status write, FSM IDLE. reset_n low mid-WR_PH -> bus idle immediately, all outputs at reset values.
